branch_predictor: RTL and testbench

//  Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters for the IF stage.

---
 rtl/branch_pred_pkg.sv | 16 +
 rtl/sat_counter2.sv | 24 ++
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// Shared encodings and constants for the branch target buffer.
// Counter states run from strongly-not-taken to strongly-taken.
package branch_pred_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_t;

    localparam cnt_state_t  INIT_BRANCH = WT;
    localparam cnt_state_t  INIT_JUMP   = ST;
    localparam int unsigned PC_INC      = 4;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// force_st takes priority over inc and dec.
module sat_counter2
    import branch_pred_pkg::*;
(
    input  cnt_state_t cur,
    input  logic       inc,
    input  logic       dec,
    input  logic       force_st,
    output cnt_state_t nxt
);

    always_comb begin
        nxt = cur;
        if (force_st) begin
            nxt = ST;
        end else if (inc && cur != ST) begin
            nxt = cnt_state_t'(cur + 2'd1);
        end else if (dec && cur != SNT) begin
            nxt = cnt_state_t'(cur - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup for IF,
// registered training from ID, and a saturating mispredict counter.
module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_pc,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_is_jump,
    input  logic [DATA_W-1:0] upd_target,
    input  logic              upd_mispredict,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [DATA_W-1:0]  target_q [ENTRIES];
    cnt_state_t         cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   mis_cnt_q;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               upd_fire;
    logic               wr_entry;
    logic               wr_target;
    logic               alloc;
    logic               sc_inc;
    logic               sc_dec;
    logic               sc_force;
    cnt_state_t         sc_nxt;
    cnt_state_t         new_cnt;
    logic               unused_upd_bits;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_upd_bits = ^{upd_pc[DATA_W-1:IDX_W+TAG_W+2], upd_pc[1:0]};

    // Lookup reads pre-update contents; no bypass from the update port.
    always_comb begin
        pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = pred_hit && cnt_q[lk_idx][1];
        pred_pc    = pred_taken ? target_q[lk_idx] : lookup_pc + DATA_W'(PC_INC);
    end

    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign upd_fire = upd_valid && enable && !rst;

    always_comb begin
        wr_entry  = 1'b0;
        wr_target = 1'b0;
        alloc     = 1'b0;
        sc_inc    = 1'b0;
        sc_dec    = 1'b0;
        sc_force  = 1'b0;
        if (upd_fire) begin
            if (up_hit) begin
                wr_entry = 1'b1;
                if (upd_is_jump) begin
                    sc_force  = 1'b1;
                    wr_target = 1'b1;
                end else begin
                    sc_inc    = upd_taken;
                    sc_dec    = !upd_taken;
                    wr_target = upd_taken;
                end
            end else if (upd_taken || upd_is_jump) begin
                wr_entry  = 1'b1;
                wr_target = 1'b1;
                alloc     = 1'b1;
            end
        end
    end

    sat_counter2 u_sat_counter2 (
        .cur      (cnt_q[up_idx]),
        .inc      (sc_inc),
        .dec      (sc_dec),
        .force_st (sc_force),
        .nxt      (sc_nxt)
    );

    assign new_cnt = alloc ? (upd_is_jump ? INIT_JUMP : INIT_BRANCH) : sc_nxt;

    always_ff @(posedge clk) begin
        if (wr_entry) begin
            cnt_q[up_idx] <= new_cnt;
            tag_q[up_idx] <= up_tag;
        end
        if (wr_target) begin
            target_q[up_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_cnt_q <= '0;
        end else if (enable && upd_valid && upd_mispredict && mis_cnt_q != '1) begin
            mis_cnt_q <= mis_cnt_q + 1'b1;
        end
    end

    assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, hysteresis, aliasing,
// jumps, same-cycle lookup/update, enable, reset priority and counter saturation.
module tb_branch_predictor;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [DATA_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_pc;
    logic              upd_valid;
    logic [DATA_W-1:0] upd_pc;
    logic              upd_taken;
    logic              upd_is_jump;
    logic [DATA_W-1:0] upd_target;
    logic              upd_mispredict;
    logic [CNT_W-1:0]  mispredict_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .DATA_W  (DATA_W),
        .ENTRIES (16),
        .TAG_W   (8),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_is_jump    (upd_is_jump),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One update cycle; upd_valid drops afterwards.
    task automatic upd(input logic [63:0] pc, input logic taken, input logic jump,
                       input logic [63:0] target, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_is_jump    = jump;
        upd_target     = target;
        upd_mispredict = mis;
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic look(input string tag, input logic [63:0] pc, input logic hit,
                        input logic taken, input logic [63:0] npc);
        lookup_pc = pc;
        #1;
        chk({tag, "_hit"}, 64'(pred_hit), 64'(hit));
        chk({tag, "_taken"}, 64'(pred_taken), 64'(taken));
        chk({tag, "_pc"}, pred_pc, npc);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; lookup_pc = 64'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_is_jump = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0;
        step();
        step();
        rst = 1'b0;
        look("reset", 64'h100, 1'b0, 1'b0, 64'h104);
        chk("reset_mcnt", 64'(mispredict_cnt), 64'h0);

        // allocate as weakly taken
        upd(64'h100, 1'b1, 1'b0, 64'h200, 1'b0);
        look("alloc", 64'h100, 1'b1, 1'b1, 64'h200);

        // hysteresis: WT -> WNT -> WT -> ST, then saturate
        upd(64'h100, 1'b0, 1'b0, 64'h200, 1'b0);
        look("wnt", 64'h100, 1'b1, 1'b0, 64'h104);
        upd(64'h100, 1'b1, 1'b0, 64'h200, 1'b0);
        upd(64'h100, 1'b1, 1'b0, 64'h200, 1'b0);
        look("st", 64'h100, 1'b1, 1'b1, 64'h200);
        for (int i = 0; i < 3; i++) upd(64'h100, 1'b1, 1'b0, 64'h200, 1'b0);
        look("st_sat", 64'h100, 1'b1, 1'b1, 64'h200);
        upd(64'h100, 1'b0, 1'b0, 64'h200, 1'b0);
        look("st_to_wt", 64'h100, 1'b1, 1'b1, 64'h200);
        upd(64'h100, 1'b0, 1'b0, 64'h200, 1'b0);
        look("wt_to_wnt", 64'h100, 1'b1, 1'b0, 64'h104);

        // target rewritten on taken, kept on not-taken
        upd(64'h100, 1'b1, 1'b0, 64'h300, 1'b0);
        look("retarget", 64'h100, 1'b1, 1'b1, 64'h300);
        upd(64'h100, 1'b1, 1'b0, 64'h300, 1'b0);
        upd(64'h100, 1'b0, 1'b0, 64'h990, 1'b0);
        look("nt_keeps_target", 64'h100, 1'b1, 1'b1, 64'h300);

        // aliasing at index 0, tag 5 vs tag 4
        look("alias_miss", 64'h140, 1'b0, 1'b0, 64'h144);
        upd(64'h140, 1'b0, 1'b0, 64'h500, 1'b0);
        look("miss_nt_nochange", 64'h100, 1'b1, 1'b1, 64'h300);
        upd(64'h140, 1'b1, 1'b0, 64'h500, 1'b0);
        look("alias_replace", 64'h140, 1'b1, 1'b1, 64'h500);
        look("alias_evicted", 64'h100, 1'b0, 1'b0, 64'h104);

        // jump on hit forces ST; one not-taken leaves it predicted taken
        upd(64'h140, 1'b0, 1'b1, 64'h600, 1'b0);
        upd(64'h140, 1'b0, 1'b0, 64'h000, 1'b0);
        look("jump_hit", 64'h140, 1'b1, 1'b1, 64'h600);

        // jump miss allocates ST, branch miss allocates WT
        upd(64'h204, 1'b0, 1'b1, 64'h700, 1'b0);
        upd(64'h204, 1'b0, 1'b0, 64'h000, 1'b0);
        look("jump_alloc", 64'h204, 1'b1, 1'b1, 64'h700);
        upd(64'h208, 1'b1, 1'b0, 64'h800, 1'b0);
        upd(64'h208, 1'b0, 1'b0, 64'h000, 1'b0);
        look("branch_alloc", 64'h208, 1'b1, 1'b0, 64'h20C);

        // same-cycle lookup and update see the old contents
        lookup_pc = 64'h100;
        upd_valid = 1'b1; upd_pc = 64'h100; upd_taken = 1'b1; upd_is_jump = 1'b0;
        upd_target = 64'h900;
        #1;
        chk("concur_old_hit", 64'(pred_hit), 64'h0);
        chk("concur_old_pc", pred_pc, 64'h104);
        step();
        upd_valid = 1'b0;
        look("concur_new", 64'h100, 1'b1, 1'b1, 64'h900);

        // upd_mispredict without upd_valid does not count
        upd_mispredict = 1'b1;
        step();
        upd_mispredict = 1'b0;
        chk("mis_no_valid", 64'(mispredict_cnt), 64'h0);

        // enable low freezes everything but lookup
        enable = 1'b0;
        upd(64'h100, 1'b0, 1'b0, 64'hBAD, 1'b1);
        look("frozen_lookup", 64'h204, 1'b1, 1'b1, 64'h700);
        enable = 1'b1;
        look("frozen_table", 64'h100, 1'b1, 1'b1, 64'h900);
        chk("frozen_mcnt", 64'(mispredict_cnt), 64'h0);

        upd(64'h100, 1'b1, 1'b0, 64'h900, 1'b1);
        chk("mcnt_one", 64'(mispredict_cnt), 64'h1);

        // reset wins over a simultaneous update
        rst = 1'b1;
        upd(64'h30C, 1'b1, 1'b0, 64'hA00, 1'b1);
        rst = 1'b0;
        look("rst_blocks_upd", 64'h30C, 1'b0, 1'b0, 64'h310);
        look("rst_clears_valid", 64'h100, 1'b0, 1'b0, 64'h104);
        chk("rst_mcnt", 64'(mispredict_cnt), 64'h0);

        // counter saturation at 4 bits
        for (int i = 0; i < 15; i++) upd(64'h100, 1'b0, 1'b0, 64'h0, 1'b1);
        chk("mcnt_15", 64'(mispredict_cnt), 64'hF);
        for (int i = 0; i < 5; i++) upd(64'h100, 1'b0, 1'b0, 64'h0, 1'b1);
        chk("mcnt_sat", 64'(mispredict_cnt), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
